// File: rtl/paddle_input_ctrl.sv
// Paddle input front end: sync + debounce both buttons, arbitrate on frame_tick, emit registered one-cycle move strobes (latency 1 from tick).
// No backpressure: strobes are fire-and-forget, ticks during a pulse are dropped. Optional double-pulse acceleration under PADDLE_ACCEL_EN.
module paddle_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000
`ifdef PADDLE_ACCEL_EN
    ,
    parameter int ACCEL_FRAMES    = 30
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    input  logic frame_tick,
    output logic move_up,
    output logic move_down,
    output logic up_held,
    output logic down_held
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
`ifdef PADDLE_ACCEL_EN
        PULSE2 = 2'd2,
`endif
        PULSE1 = 2'd1
    } state_e;

    logic [1:0] raw_w;
    logic [1:0] held_w;

    assign raw_w = {btn_down_raw, btn_up_raw};

    // Bit 0 is the up button, bit 1 the down button.
    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic             sync1_q, sync2_q;
        logic             held_q, held_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            held_d = held_q;
            cnt_d  = '0;
            if (sync2_q != held_q) begin
                if (cnt_q == DB_LAST) begin
                    held_d = ~held_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                held_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= raw_w[b];
                sync2_q <= sync1_q;
                held_q  <= held_d;
                cnt_q   <= cnt_d;
            end
        end

        assign held_w[b] = held_q;
    end

    dir_e dir_w;

    always_comb begin
        dir_w = DIR_NONE;
        if (held_w[0] && !held_w[1]) begin
            dir_w = DIR_UP;
        end else if (held_w[1] && !held_w[0]) begin
            dir_w = DIR_DN;
        end
    end

`ifdef PADDLE_ACCEL_EN
    localparam int                HOLD_W   = $clog2(ACCEL_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(ACCEL_FRAMES);

    dir_e              prev_dir_q, prev_dir_d;
    dir_e              dir_q, dir_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              accel_q, accel_d;

    // hold_d already includes the current tick, so the Nth repeat of a direction accelerates.
    always_comb begin
        prev_dir_d = prev_dir_q;
        hold_d     = hold_q;
        if (frame_tick) begin
            prev_dir_d = dir_w;
            if (dir_w != DIR_NONE && dir_w == prev_dir_q) begin
                if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end else begin
                hold_d = '0;
            end
        end
    end
`endif

    state_e state_q, state_d;
    logic   move_up_q, move_up_d;
    logic   move_down_q, move_down_d;

    always_comb begin
        state_d     = state_q;
        move_up_d   = 1'b0;
        move_down_d = 1'b0;
`ifdef PADDLE_ACCEL_EN
        dir_d       = dir_q;
        accel_d     = accel_q;
`endif
        case (state_q)
            IDLE: begin
                if (frame_tick && dir_w != DIR_NONE) begin
                    state_d     = PULSE1;
                    move_up_d   = (dir_w == DIR_UP);
                    move_down_d = (dir_w == DIR_DN);
`ifdef PADDLE_ACCEL_EN
                    dir_d       = dir_w;
                    accel_d     = (hold_d == HOLD_MAX);
`endif
                end
            end
            PULSE1: begin
                state_d = IDLE;
`ifdef PADDLE_ACCEL_EN
                // Second pulse only if the debounced direction still matches the latched one.
                if (accel_q) begin
                    state_d     = PULSE2;
                    move_up_d   = (dir_q == DIR_UP) && (dir_w == dir_q);
                    move_down_d = (dir_q == DIR_DN) && (dir_w == dir_q);
                end
`endif
            end
`ifdef PADDLE_ACCEL_EN
            PULSE2: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            move_up_q   <= 1'b0;
            move_down_q <= 1'b0;
`ifdef PADDLE_ACCEL_EN
            dir_q       <= DIR_NONE;
            accel_q     <= 1'b0;
            prev_dir_q  <= DIR_NONE;
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            move_up_q   <= move_up_d;
            move_down_q <= move_down_d;
`ifdef PADDLE_ACCEL_EN
            dir_q       <= dir_d;
            accel_q     <= accel_d;
            prev_dir_q  <= prev_dir_d;
            hold_q      <= hold_d;
`endif
        end
    end

    assign move_up   = move_up_q;
    assign move_down = move_down_q;
    assign up_held   = held_w[0];
    assign down_held = held_w[1];

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Directed bench for paddle_input_ctrl with DEBOUNCE_CYCLES=4 (ACCEL_FRAMES=3 when PADDLE_ACCEL_EN is defined).
module tb_paddle_input_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic btn_up_raw;
    logic btn_down_raw;
    logic frame_tick;
    logic move_up;
    logic move_down;
    logic up_held;
    logic down_held;

    int n_checks = 0;
    int n_pass   = 0;
    int both_cnt = 0;

`ifdef PADDLE_ACCEL_EN
    localparam logic [3:0] ACC_UP = 4'b0110;
`else
    localparam logic [3:0] ACC_UP = 4'b0010;
`endif

    paddle_input_ctrl #(
        .DEBOUNCE_CYCLES(4)
`ifdef PADDLE_ACCEL_EN
        ,
        .ACCEL_FRAMES(3)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_up_raw   (btn_up_raw),
        .btn_down_raw (btn_down_raw),
        .frame_tick   (frame_tick),
        .move_up      (move_up),
        .move_down    (move_down),
        .up_held      (up_held),
        .down_held    (down_held)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (move_up && move_down) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise frame_tick for one cycle T and record move_* at cycles T..T+3 (bit i = cycle T+i).
    task automatic frame_pulse(input string tag, input logic [3:0] exp_up, input logic [3:0] exp_dn);
        logic [3:0] obs_up;
        logic [3:0] obs_dn;
        frame_tick = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            obs_up[i] = move_up;
            obs_dn[i] = move_down;
            step(1);
            frame_tick = 1'b0;
        end
        check({tag, "/up"}, {28'd0, obs_up}, {28'd0, exp_up});
        check({tag, "/dn"}, {28'd0, obs_dn}, {28'd0, exp_dn});
    endtask

    initial begin
        logic [3:0] obs;
        logic       seen;

        rst          = 1'b1;
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        frame_tick   = 1'b0;
        step(3);
        @(negedge clk);
        check("rst_move_up",   {31'd0, move_up},   32'd0);
        check("rst_move_down", {31'd0, move_down}, 32'd0);
        check("rst_up_held",   {31'd0, up_held},   32'd0);
        check("rst_down_held", {31'd0, down_held}, 32'd0);
        step(1);
        rst = 1'b0;

        // Clean press at cycle 10 -> up_held at cycle 16.
        step(10);
        btn_up_raw = 1'b1;
        step(5);
        @(negedge clk);
        check("db_lat_c15", {31'd0, up_held}, 32'd0);
        step(1);
        @(negedge clk);
        check("db_lat_c16", {31'd0, up_held}, 32'd1);
        check("db_down_idle", {31'd0, down_held}, 32'd0);
        step(2);
        frame_pulse("single_up", 4'b0010, 4'b0000);

        // Release, then a 3-cycle glitch must be filtered.
        btn_up_raw = 1'b0;
        step(8);
        @(negedge clk);
        check("release_up", {31'd0, up_held}, 32'd0);
        step(1);
        btn_up_raw = 1'b1;
        step(3);
        btn_up_raw = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | up_held;
            step(1);
        end
        check("glitch3", {31'd0, seen}, 32'd0);
        frame_pulse("glitch3_tick", 4'b0000, 4'b0000);

        // A pulse of exactly DEBOUNCE_CYCLES does get through, then returns low.
        btn_up_raw = 1'b1;
        step(4);
        btn_up_raw = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen = seen | up_held;
            step(1);
        end
        check("glitch4", {31'd0, seen}, 32'd1);
        @(negedge clk);
        check("glitch4_settle", {31'd0, up_held}, 32'd0);
        step(1);

        // Both held: arbitration blocks every tick.
        btn_up_raw   = 1'b1;
        btn_down_raw = 1'b1;
        step(8);
        @(negedge clk);
        check("both_up_held", {31'd0, up_held}, 32'd1);
        check("both_dn_held", {31'd0, down_held}, 32'd1);
        step(1);
        for (int k = 0; k < 5; k++) begin
            frame_pulse($sformatf("both_t%0d", k), 4'b0000, 4'b0000);
        end
        btn_down_raw = 1'b0;
        step(8);
        frame_pulse("both_release_dn", 4'b0010, 4'b0000);

        // Down only; second tick while in PULSE1 is ignored.
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b1;
        step(8);
        @(negedge clk);
        check("dn_only_held", {31'd0, down_held}, 32'd1);
        check("dn_only_up_rel", {31'd0, up_held}, 32'd0);
        step(1);
        frame_tick = 1'b1;
        @(negedge clk);
        obs[0] = move_down;
        step(1);
        @(negedge clk);
        obs[1] = move_down;
        step(1);
        frame_tick = 1'b0;
        @(negedge clk);
        obs[2] = move_down;
        step(1);
        @(negedge clk);
        obs[3] = move_down;
        check("dbl_tick_dn", {28'd0, obs}, 32'h2);

        // Reset during the pulse cycle aborts everything.
        step(2);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        check("rst_mid_pre", {31'd0, move_down}, 32'd1);
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_dn",      {31'd0, move_down}, 32'd0);
        check("rst_mid_up",      {31'd0, move_up},   32'd0);
        check("rst_mid_dn_held", {31'd0, down_held}, 32'd0);
        check("rst_mid_up_held", {31'd0, up_held},   32'd0);
        step(1);
        @(negedge clk);
        check("rst_mid_after", {31'd0, move_down}, 32'd0);
        btn_down_raw = 1'b0;
        step(10);

        // Continuous up hold: the 4th tick onward accelerates when enabled.
        btn_up_raw = 1'b1;
        step(8);
        for (int k = 1; k <= 3; k++) begin
            frame_pulse($sformatf("hold_t%0d", k), 4'b0010, 4'b0000);
        end
        for (int k = 4; k <= 5; k++) begin
            frame_pulse($sformatf("hold_t%0d", k), ACC_UP, 4'b0000);
        end

        // Down debounces in exactly the PULSE1 cycle of an accelerated tick.
        btn_down_raw = 1'b1;
        step(5);
        frame_pulse("accel_abort", 4'b0010, 4'b0000);
        frame_pulse("abort_both", 4'b0000, 4'b0000);
        btn_down_raw = 1'b0;
        step(8);
        frame_pulse("post_clear1", 4'b0010, 4'b0000);
        frame_pulse("post_clear2", 4'b0010, 4'b0000);

        check("never_both", both_cnt, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
